// File: rtl/mmu_tlb_lock_arb_pkg.sv
// mmu_tlb_lock_arb_pkg: shared TLB lookup types, arbiter defaults and round-robin index helper
package mmu_tlb_lock_arb_pkg;

    localparam int N_TLB_CHAN    = 4;
    localparam int TLB_ADDR_BITS = 48;
    localparam int TLB_PID_BITS  = 6;

    typedef struct packed {
        logic [TLB_ADDR_BITS-1:0] addr;
        logic [TLB_PID_BITS-1:0]  pid;
        logic                     strm;
        logic                     wr;
    } tlb_lookup_t;

    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mmu_tlb_lock_arb_rr_pick.sv
// mmu_rr_pick: combinational round-robin picker, first eligible request at or above ptr with wrap
module mmu_rr_pick
    import mmu_tlb_lock_arb_pkg::*;
#(
    parameter  int N  = N_TLB_CHAN,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  pick_oh,
    output logic [IW-1:0] pick_id,
    output logic          any
);

    logic [N-1:0]  elig;
    logic [IW-1:0] idx;

    assign elig = req & ~excl;

    // scan from ptr upward, wrapping, and keep the first eligible channel
    always_comb begin
        pick_oh = '0;
        pick_id = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'(rr_idx(int'(ptr), i, N));
            if (!any && elig[idx]) begin
                any          = 1'b1;
                pick_oh[idx] = 1'b1;
                pick_id      = idx;
            end
        end
    end

endmodule

// File: rtl/mmu_tlb_lock_arb.sv
// mmu_tlb_lock_arb: N-channel TLB lookup-port mutex with round-robin grant and owner mux
// Optional forced release of a stuck owner when MMU_ARB_TIMEOUT_EN is defined.
module mmu_tlb_lock_arb
    import mmu_tlb_lock_arb_pkg::*;
#(
    parameter  int N_CHAN      = N_TLB_CHAN,
    parameter  int ADDR_BITS   = TLB_ADDR_BITS,
    parameter  int PID_BITS    = TLB_PID_BITS,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int IW          = $clog2(N_CHAN)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_CHAN-1:0]             lock_req,
    input  logic [N_CHAN-1:0]             unlock,
    output logic [N_CHAN-1:0]             grant_oh,
    output logic                          mutex_free,
    output logic [IW-1:0]                 owner_id,
    input  logic [N_CHAN*ADDR_BITS-1:0]   s_addr,
    input  logic [N_CHAN*PID_BITS-1:0]    s_pid,
    input  logic [N_CHAN-1:0]             s_strm,
    input  logic [N_CHAN-1:0]             s_wr,
    input  logic [N_CHAN-1:0]             s_valid,
    output logic [ADDR_BITS-1:0]          m_addr,
    output logic [PID_BITS-1:0]           m_pid,
    output logic                          m_strm,
    output logic                          m_wr,
    output logic                          m_valid,
    output logic                          timeout_err,
    output logic [IW-1:0]                 timeout_id
);

    localparam logic [0:0] FREE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]        state;
    logic [IW-1:0]     rr_ptr;
    logic              rel;
    logic              expire;
    logic              go_pick;
    logic [N_CHAN-1:0] excl;
    logic [N_CHAN-1:0] pick_oh;
    logic [IW-1:0]     pick_id;
    logic              pick_any;

    // only the owner's unlock counts; others are ignored
    assign rel     = (state == LOCKED) && unlock[owner_id];
    assign go_pick = (state == FREE) || rel || expire;
    // the channel giving up the lock may not win it straight back
    assign excl    = (rel || expire) ? grant_oh : '0;

    mmu_rr_pick #(.N(N_CHAN)) u_pick (
        .req     (lock_req),
        .ptr     (rr_ptr),
        .excl    (excl),
        .pick_oh (pick_oh),
        .pick_id (pick_id),
        .any     (pick_any)
    );

`ifdef MMU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] hold_cnt;

    assign expire = (state == LOCKED) && !rel && (hold_cnt == CW'(TIMEOUT_CYC - 1));

    // hold timer restarts on every grant or handover and runs while locked
    always_ff @(posedge aclk) begin
        if (!aresetn)
            hold_cnt <= '0;
        else
            hold_cnt <= go_pick ? '0 : hold_cnt + 1'b1;
    end

    // one-cycle forced-release flag tagged with the evicted owner
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            timeout_err <= expire;
            if (expire) timeout_id <= owner_id;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
    assign timeout_id  = '0;
`endif

    // FREE/LOCKED ownership with direct handover and round-robin pointer advance
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= FREE;
            grant_oh   <= '0;
            mutex_free <= 1'b1;
            owner_id   <= '0;
            rr_ptr     <= '0;
        end else if (go_pick) begin
            if (pick_any) begin
                state      <= LOCKED;
                grant_oh   <= pick_oh;
                mutex_free <= 1'b0;
                owner_id   <= pick_id;
                rr_ptr     <= (pick_id == IW'(N_CHAN - 1)) ? '0 : pick_id + 1'b1;
            end else begin
                state      <= FREE;
                grant_oh   <= '0;
                mutex_free <= 1'b1;
            end
        end
    end

    // zero-latency mux of the owner's lookup; all zero while free
    always_comb begin
        m_addr  = '0;
        m_pid   = '0;
        m_strm  = 1'b0;
        m_wr    = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (state == LOCKED && grant_oh[i]) begin
                m_addr  = s_addr[i*ADDR_BITS +: ADDR_BITS];
                m_pid   = s_pid[i*PID_BITS +: PID_BITS];
                m_strm  = s_strm[i];
                m_wr    = s_wr[i];
                m_valid = s_valid[i];
            end
        end
    end

endmodule

// File: tb/tb_mmu_tlb_lock_arb.sv
// tb_mmu_tlb_lock_arb: vector table, directed corner cases and randomized model check of the TLB lock arbiter
module tb_mmu_tlb_lock_arb;

    localparam int N  = 4;
    localparam int AB = 48;
    localparam int PB = 6;
    localparam int TO = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [N-1:0]  lock_req = '0, unlock = '0, s_strm = '0, s_wr = '0, s_valid = '0;
    logic [N*AB-1:0] s_addr = '0;
    logic [N*PB-1:0] s_pid = '0;
    logic [N-1:0]  grant_oh;
    logic          mutex_free, m_strm, m_wr, m_valid, timeout_err;
    logic [1:0]    owner_id, timeout_id;
    logic [AB-1:0] m_addr;
    logic [PB-1:0] m_pid;

    int total = 0;
    int bad   = 0;

    int mo, mp, mc, mid, mtid;
    bit mterr;

    typedef struct {
        bit         rst;
        logic [3:0] lr;
        logic [3:0] ul;
        logic [3:0] g;
        logic       f;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[$];

    mmu_tlb_lock_arb #(.N_CHAN(N), .ADDR_BITS(AB), .PID_BITS(PB), .TIMEOUT_CYC(TO)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .lock_req    (lock_req),
        .unlock      (unlock),
        .grant_oh    (grant_oh),
        .mutex_free  (mutex_free),
        .owner_id    (owner_id),
        .s_addr      (s_addr),
        .s_pid       (s_pid),
        .s_strm      (s_strm),
        .s_wr        (s_wr),
        .s_valid     (s_valid),
        .m_addr      (m_addr),
        .m_pid       (m_pid),
        .m_strm      (m_strm),
        .m_wr        (m_wr),
        .m_valid     (m_valid),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mo = -1; mp = 0; mc = 0; mid = 0; mtid = 0; mterr = 0;
    endtask

    // ownership rules stated as: who owns, who may pick, scan order from the pointer
    task automatic model_step(input logic [3:0] lr, input logic [3:0] ul);
        int excl = -1;
        int nxt  = -1;
        bit pick = 0;
        mterr = 0;
        if (mo < 0) pick = 1;
        else if (ul[mo]) begin pick = 1; excl = mo; end
`ifdef MMU_ARB_TIMEOUT_EN
        else if (mc == TO - 1) begin pick = 1; excl = mo; mterr = 1; mtid = mo; end
`endif
        if (!pick) begin
            mc++;
            return;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (mp + k) % N;
            if (nxt < 0 && lr[c] && c != excl) nxt = c;
        end
        mc = 0;
        if (nxt >= 0) begin mo = nxt; mid = nxt; mp = (nxt + 1) % N; end
        else mo = -1;
    endtask

    function automatic logic [63:0] exp_mux();
        if (mo < 0) return 64'd0;
        return 64'({s_valid[mo], s_strm[mo], s_wr[mo], s_pid[mo*PB +: PB], s_addr[mo*AB +: AB]});
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " grant_oh"},    grant_oh,    (mo >= 0) ? 64'(4'b0001 << mo) : 64'd0);
        chk({tag, " mutex_free"},  mutex_free,  64'(mo < 0));
        chk({tag, " owner_id"},    owner_id,    64'(mid));
        chk({tag, " timeout_err"}, timeout_err, 64'(mterr));
        chk({tag, " timeout_id"},  timeout_id,  64'(mtid));
    endtask

    task automatic step(input bit rst, input logic [3:0] lr, input logic [3:0] ul);
        aresetn  = !rst;
        lock_req = lr;
        unlock   = ul;
        @(posedge aclk);
        if (rst) model_reset();
        else model_step(lr, ul);
        #1;
        aresetn = 1'b1;
        unlock  = '0;
    endtask

    task automatic add(input bit rst, input logic [3:0] lr, ul, g, input logic f, input logic [1:0] id);
        vec_t v;
        v.rst = rst; v.lr = lr; v.ul = ul; v.g = g; v.f = f; v.id = id;
        tbl.push_back(v);
    endtask

    task automatic rand_lookup();
        for (int c = 0; c < N; c++) begin
            s_addr[c*AB +: AB] = AB'({$urandom, $urandom});
            s_pid[c*PB +: PB]  = PB'($urandom);
        end
        s_strm  = 4'($urandom);
        s_wr    = 4'($urandom);
        s_valid = 4'($urandom);
    endtask

    initial begin
        int n;
        logic [3:0] lr, ul;
        int r;

        add(0, 4'b0101, 4'b0000, 4'b0001, 0, 0);
        add(0, 4'b0100, 4'b0001, 4'b0100, 0, 2);
        add(0, 4'b0000, 4'b0010, 4'b0100, 0, 2);
        add(0, 4'b0000, 4'b0100, 4'b0000, 1, 2);
        add(0, 4'b0011, 4'b0000, 4'b0001, 0, 0);
        add(0, 4'b0010, 4'b0001, 4'b0010, 0, 1);
        add(0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 1, 1);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0, 2);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 0);
        add(0, 4'b1111, 4'b0001, 4'b0010, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 0, 1);
        add(0, 4'b1111, 4'b0010, 4'b0100, 0, 2);
        add(0, 4'b1111, 4'b0000, 4'b0100, 0, 2);
        add(0, 4'b1111, 4'b0100, 4'b1000, 0, 3);
        add(0, 4'b1111, 4'b0000, 4'b1000, 0, 3);
        add(0, 4'b1111, 4'b1000, 4'b0001, 0, 0);

        model_reset();
        s_valid = 4'b1111;
        repeat (2) @(posedge aclk);
        #1;
        chk("reset grant_oh", grant_oh, 0);
        chk("reset mutex_free", mutex_free, 1);
        chk("reset owner_id", owner_id, 0);
        chk("reset timeout_err", timeout_err, 0);
        chk("reset timeout_id", timeout_id, 0);
        chk("reset m_valid", m_valid, 0);
        aresetn = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].lr, tbl[i].ul);
            chk($sformatf("vec%0d grant_oh", i), grant_oh, tbl[i].g);
            chk($sformatf("vec%0d mutex_free", i), mutex_free, tbl[i].f);
            chk($sformatf("vec%0d owner_id", i), owner_id, tbl[i].id);
            chk($sformatf("vec%0d timeout_err", i), timeout_err, 0);
        end

        // owner 1 lookup passes through, channel 3 valid is dropped
        step(0, 4'b0010, 4'b0001);
        chk("mux owner", grant_oh, 4'b0010);
        rand_lookup();
        s_addr[1*AB +: AB] = 48'h1000;
        s_pid[1*PB +: PB]  = 6'h2a;
        s_strm  = 4'b0010;
        s_wr    = 4'b0000;
        s_valid = 4'b1000;
        #2;
        chk("mux m_addr", m_addr, 48'h1000);
        chk("mux m_pid", m_pid, 6'h2a);
        chk("mux m_strm", m_strm, 1);
        chk("mux m_wr", m_wr, 0);
        chk("mux m_valid nonowner", m_valid, 0);
        s_valid = 4'b1010;
        #1;
        chk("mux m_valid owner", m_valid, 1);
        step(0, 4'b0000, 4'b0010);
        s_valid = 4'b1111;
        #1;
        chk("free m_valid", m_valid, 0);
        chk("free m_addr", m_addr, 0);

        // owner 3 holds without unlocking
        step(1, 4'b0000, 4'b0000);
        step(0, 4'b1000, 4'b0000);
        check_model("hold grant");
        n = 1;
        for (int k = 0; k < 40 && grant_oh == 4'b1000; k++) begin
            step(0, 4'b0000, 4'b0000);
            check_model("hold");
            if (grant_oh == 4'b1000) n++;
        end
`ifdef MMU_ARB_TIMEOUT_EN
        chk("timeout locked cycles", n, TO);
        chk("timeout_err pulse", timeout_err, 1);
        chk("timeout_id", timeout_id, 3);
        step(0, 4'b0000, 4'b0000);
        chk("timeout_err cleared", timeout_err, 0);
        step(0, 4'b1000, 4'b0000);
        repeat (TO - 1) step(0, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b1000);
        check_model("unlock at expiry");
        chk("unlock at expiry no err", timeout_err, 0);
        chk("unlock at expiry free", mutex_free, 1);
`else
        chk("no timeout locked cycles", n, 41);
        chk("no timeout err", timeout_err, 0);
        chk("no timeout still owner", grant_oh, 4'b1000);
`endif

        for (int k = 0; k < 600; k++) begin
            rand_lookup();
            #2;
            chk($sformatf("rnd%0d mux", k), 64'({m_valid, m_strm, m_wr, m_pid, m_addr}), exp_mux());
            lr = 4'($urandom);
            r  = $urandom_range(0, 9);
            ul = (r < 3 && mo >= 0) ? 4'(4'b0001 << mo) : (r == 3) ? 4'($urandom) : 4'b0000;
            step($urandom_range(0, 99) == 0, lr, ul);
            check_model($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
